obj_affine_walker: RTL and testbench

//  Parametrised, pipelined successor to the per-pixel OBJ rotation/scale math in graphics/obj.

---
 rtl/obj_affine_walker_pkg.sv | 17 +
 rtl/obj_affine_walker_if.sv | 24 ++
 rtl/obj_affine_walker_setup.sv | 41 ++++
 rtl/obj_affine_walker.sv | 166 ++++++++++++++++
 tb/tb_obj_affine_walker.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/obj_affine_walker_pkg.sv
// Shared types and default constants for the affine OBJ walker and its setup unit.
package obj_affine_walker_pkg;

  localparam int DEF_PARAM_W  = 16;
  localparam int DEF_FRAC     = 8;
  localparam int DEF_TEX_LOG2 = 6;
  localparam int SCREEN_W     = 240;

  typedef logic signed [DEF_PARAM_W-1:0] affine_param_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WALK
  } obj_affine_state_t;

endpackage

// File: rtl/obj_affine_walker_if.sv
// Output beat bus from the affine walker to the tile/palette fetch stage.
interface obj_affine_walker_if #(
  parameter int TEX_LOG2 = 6
);

  logic                out_valid;
  logic                out_ready;
  logic [8:0]          out_col;
  logic [TEX_LOG2-1:0] out_x;
  logic [TEX_LOG2-1:0] out_y;
  logic                out_transp;
  logic                out_last;

  modport master (
    output out_valid, out_col, out_x, out_y, out_transp, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_col, out_x, out_y, out_transp, out_last,
    output out_ready
  );

endinterface

// File: rtl/obj_affine_walker_setup.sv
// Initial texture coordinate for the leftmost box pixel: pa*dx0 + pb*dy + centre bias (and pc/pd for y).
module obj_affine_walker_setup
  import obj_affine_walker_pkg::*;
#(
  parameter int PARAM_W  = DEF_PARAM_W,
  parameter int FRAC     = DEF_FRAC,
  parameter int TEX_LOG2 = DEF_TEX_LOG2,
  parameter int ACC_W    = PARAM_W + TEX_LOG2 + 4,
  parameter int OFF_W    = 10
) (
  input  logic signed [PARAM_W-1:0] pa,
  input  logic signed [PARAM_W-1:0] pb,
  input  logic signed [PARAM_W-1:0] pc,
  input  logic signed [PARAM_W-1:0] pd,
  input  logic signed [OFF_W-1:0]   dx0,
  input  logic signed [OFF_W-1:0]   dy,
  input  logic [TEX_LOG2:0]         hsize,
  input  logic [TEX_LOG2:0]         vsize,
  output logic signed [ACC_W-1:0]   tx0,
  output logic signed [ACC_W-1:0]   ty0
);

  logic signed [ACC_W-1:0] pa_e, pb_e, pc_e, pd_e;
  logic signed [ACC_W-1:0] dx_e, dy_e;
  logic signed [ACC_W-1:0] bias_x, bias_y;

  // Everything is widened to the accumulator first so the products cannot overflow.
  always_comb begin
    pa_e   = {{(ACC_W-PARAM_W){pa[PARAM_W-1]}}, pa};
    pb_e   = {{(ACC_W-PARAM_W){pb[PARAM_W-1]}}, pb};
    pc_e   = {{(ACC_W-PARAM_W){pc[PARAM_W-1]}}, pc};
    pd_e   = {{(ACC_W-PARAM_W){pd[PARAM_W-1]}}, pd};
    dx_e   = {{(ACC_W-OFF_W){dx0[OFF_W-1]}}, dx0};
    dy_e   = {{(ACC_W-OFF_W){dy[OFF_W-1]}}, dy};
    bias_x = {{(ACC_W-TEX_LOG2-1){1'b0}}, hsize} << (FRAC-1);
    bias_y = {{(ACC_W-TEX_LOG2-1){1'b0}}, vsize} << (FRAC-1);
    tx0    = pa_e * dx_e + pb_e * dy_e + bias_x;
    ty0    = pc_e * dx_e + pd_e * dy_e + bias_y;
  end

endmodule

// File: rtl/obj_affine_walker.sv
// Walks one affine sprite's box across a scanline, emitting one texel coordinate per accepted beat.
module obj_affine_walker
  import obj_affine_walker_pkg::*;
#(
  parameter int PARAM_W  = DEF_PARAM_W,
  parameter int FRAC     = DEF_FRAC,
  parameter int TEX_LOG2 = DEF_TEX_LOG2,
  parameter int ACC_W    = PARAM_W + TEX_LOG2 + 4
) (
  input  logic                      clock,
  input  logic                      reset_L,
  input  logic                      start,
  output logic                      start_ready,
  input  logic                      abort,
  input  logic [7:0]                row,
  input  logic [8:0]                objx,
  input  logic [7:0]                objy,
  input  logic [TEX_LOG2:0]         hsize,
  input  logic [TEX_LOG2:0]         vsize,
  input  logic                      dblsize,
  input  logic signed [PARAM_W-1:0] pa,
  input  logic signed [PARAM_W-1:0] pb,
  input  logic signed [PARAM_W-1:0] pc,
  input  logic signed [PARAM_W-1:0] pd,
  obj_affine_walker_if.master       bus
);

  localparam int OFF_W = (TEX_LOG2 + 4 > 10) ? TEX_LOG2 + 4 : 10;
  localparam int CNT_W = TEX_LOG2 + 2;

  obj_affine_state_t state_q, state_d;

  logic [7:0]                row_q, objy_q;
  logic [8:0]                objx_q;
  logic [TEX_LOG2:0]         hsize_q, vsize_q;
  logic                      dblsize_q;
  logic signed [PARAM_W-1:0] pa_q, pb_q, pc_q, pd_q;

  logic signed [ACC_W-1:0]   tx_q, ty_q, tx0, ty0, pa_step, pc_step;
  logic [CNT_W-1:0]          i_q, bw, hbw, hbh;
  logic [7:0]                rel_y;
  logic signed [OFF_W-1:0]   dx0, dy;
  logic [ACC_W-FRAC-1:0]     tx_int, ty_int;
  logic                      start_fire, beat_fire, last_beat;

  assign start_fire = (state_q == IDLE) && start && !abort;
  assign beat_fire  = (state_q == WALK) && bus.out_ready && !abort;

  // Box geometry and the pixel offsets of the box's left edge relative to its centre.
  always_comb begin
    bw        = dblsize_q ? {hsize_q, 1'b0} : {1'b0, hsize_q};
    hbw       = dblsize_q ? {1'b0, hsize_q} : {2'b00, hsize_q[TEX_LOG2:1]};
    hbh       = dblsize_q ? {1'b0, vsize_q} : {2'b00, vsize_q[TEX_LOG2:1]};
    rel_y     = row_q - objy_q;
    dx0       = -$signed({{(OFF_W-CNT_W){1'b0}}, hbw});
    dy        = $signed({{(OFF_W-8){1'b0}}, rel_y}) - $signed({{(OFF_W-CNT_W){1'b0}}, hbh});
    pa_step   = {{(ACC_W-PARAM_W){pa_q[PARAM_W-1]}}, pa_q};
    pc_step   = {{(ACC_W-PARAM_W){pc_q[PARAM_W-1]}}, pc_q};
    last_beat = (i_q == bw - CNT_W'(1));
    tx_int    = tx_q[ACC_W-1:FRAC];
    ty_int    = ty_q[ACC_W-1:FRAC];
  end

  obj_affine_walker_setup #(
    .PARAM_W  (PARAM_W),
    .FRAC     (FRAC),
    .TEX_LOG2 (TEX_LOG2),
    .ACC_W    (ACC_W),
    .OFF_W    (OFF_W)
  ) u_setup (
    .pa    (pa_q),
    .pb    (pb_q),
    .pc    (pc_q),
    .pd    (pd_q),
    .dx0   (dx0),
    .dy    (dy),
    .hsize (hsize_q),
    .vsize (vsize_q),
    .tx0   (tx0),
    .ty0   (ty0)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = SETUP;
        SETUP:   state_d = WALK;
        WALK:    if (bus.out_ready && last_beat) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sprite parameters are captured once on start so upstream may move on immediately.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      row_q     <= '0;
      objx_q    <= '0;
      objy_q    <= '0;
      hsize_q   <= '0;
      vsize_q   <= '0;
      dblsize_q <= 1'b0;
      pa_q      <= '0;
      pb_q      <= '0;
      pc_q      <= '0;
      pd_q      <= '0;
    end else if (start_fire) begin
      row_q     <= row;
      objx_q    <= objx;
      objy_q    <= objy;
      hsize_q   <= hsize;
      vsize_q   <= vsize;
      dblsize_q <= dblsize;
      pa_q      <= pa;
      pb_q      <= pb;
      pc_q      <= pc;
      pd_q      <= pd;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      tx_q <= '0;
      ty_q <= '0;
      i_q  <= '0;
    end else if (state_q == SETUP) begin
      tx_q <= tx0;
      ty_q <= ty0;
      i_q  <= '0;
    end else if (beat_fire) begin
      tx_q <= tx_q + pa_step;
      ty_q <= ty_q + pc_step;
      i_q  <= i_q + CNT_W'(1);
    end
  end

  // Beat fields are forced to their idle values outside WALK so a stale accumulator never leaks.
  always_comb begin
    start_ready    = (state_q == IDLE);
    bus.out_valid  = 1'b0;
    bus.out_col    = '0;
    bus.out_x      = '0;
    bus.out_y      = '0;
    bus.out_transp = 1'b1;
    bus.out_last   = 1'b0;
    if (state_q == WALK) begin
      bus.out_valid  = 1'b1;
      bus.out_col    = objx_q + 9'(i_q);
      bus.out_x      = tx_q[FRAC +: TEX_LOG2];
      bus.out_y      = ty_q[FRAC +: TEX_LOG2];
      bus.out_transp = tx_q[ACC_W-1] | ty_q[ACC_W-1]
                     | (tx_int >= (ACC_W-FRAC)'(hsize_q))
                     | (ty_int >= (ACC_W-FRAC)'(vsize_q));
      bus.out_last   = last_beat;
    end
  end

endmodule

// File: tb/tb_obj_affine_walker.sv
// Directed bench for obj_affine_walker: each line is checked beat by beat against a direct affine model.
module tb_obj_affine_walker;
  import obj_affine_walker_pkg::*;

  logic          clock = 1'b0;
  logic          reset_L = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          start_ready;
  logic [7:0]    row = '0;
  logic [8:0]    objx = '0;
  logic [7:0]    objy = '0;
  logic [6:0]    hsize = '0;
  logic [6:0]    vsize = '0;
  logic          dblsize = 1'b0;
  affine_param_t pa = '0, pb = '0, pc = '0, pd = '0;

  logic [8:0]    m_objx;
  logic [7:0]    m_objy, m_row;
  logic [6:0]    m_hs, m_vs;
  logic          m_dbl;
  affine_param_t m_pa, m_pb, m_pc, m_pd;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  obj_affine_walker_if #(.TEX_LOG2(6)) bus ();

  obj_affine_walker #(
    .PARAM_W  (16),
    .FRAC     (8),
    .TEX_LOG2 (6)
  ) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .start       (start),
    .start_ready (start_ready),
    .abort       (abort),
    .row         (row),
    .objx        (objx),
    .objy        (objy),
    .hsize       (hsize),
    .vsize       (vsize),
    .dblsize     (dblsize),
    .pa          (pa),
    .pb          (pb),
    .pc          (pc),
    .pd          (pd),
    .bus         (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Texel for beat i straight from the affine definition (no incremental stepping).
  function automatic void model(input int i, output logic [8:0] col, output logic [5:0] x,
                                output logic [5:0] y, output logic tr, output logic last);
    int bw, hbw, hbh, dy, dx;
    longint tx, ty, ix, iy;
    bw  = int'(m_hs) << m_dbl;
    hbw = bw / 2;
    hbh = (int'(m_vs) << m_dbl) / 2;
    dy  = ((int'(m_row) - int'(m_objy)) & 255) - hbh;
    dx  = i - hbw;
    tx  = longint'(m_pa) * dx + longint'(m_pb) * dy + longint'(m_hs / 2) * 256;
    ty  = longint'(m_pc) * dx + longint'(m_pd) * dy + longint'(m_vs / 2) * 256;
    ix  = tx >>> 8;
    iy  = ty >>> 8;
    x   = ix[5:0];
    y   = iy[5:0];
    tr  = (tx < 0) || (ty < 0) || (ix >= longint'(m_hs)) || (iy >= longint'(m_vs));
    col = 9'((int'(m_objx) + i) % 512);
    last = (i == bw - 1);
  endfunction

  task automatic applyStimulus(input logic [8:0] ox, input logic [7:0] oy, input logic [7:0] r,
                               input logic [6:0] hs, input logic [6:0] vs, input logic dbl,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d);
    @(negedge clock);
    checkOutput("start_ready_idle", start_ready, 1);
    objx = ox; objy = oy; row = r; hsize = hs; vsize = vs; dblsize = dbl;
    pa = a; pb = b; pc = c; pd = d;
    m_objx = ox; m_objy = oy; m_row = r; m_hs = hs; m_vs = vs; m_dbl = dbl;
    m_pa = a; m_pb = b; m_pc = c; m_pd = d;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    objx = 9'h1FF; objy = 8'h77; row = 8'hFF; hsize = 7'd8; vsize = 7'd8; dblsize = ~dbl;
    pa = 16'h5A5A; pb = 16'hA5A5; pc = 16'h1234; pd = 16'h8765;
  endtask

  task automatic runLine(input bit random_ready, input int abort_at);
    int k, cyc, bwl;
    bit seen;
    logic rdy;
    logic [8:0] ec;
    logic [5:0] ex, ey;
    logic et, el;
    bwl  = int'(m_hs) << m_dbl;
    k    = 0;
    cyc  = 0;
    seen = 1'b0;
    while (k < bwl && cyc < 1000) begin
      @(negedge clock);
      cyc++;
      rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      if (cyc == 1) checkOutput("setup_valid", bus.out_valid, 0);
      if (bus.out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          checkOutput("latency", cyc, 2);
        end
        if (abort_at >= 0 && k == abort_at) begin
          abort = 1'b1;
          bus.out_ready = 1'b1;
          @(posedge clock);
          #1;
          abort = 1'b0;
          @(negedge clock);
          checkOutput("abort_valid", bus.out_valid, 0);
          checkOutput("abort_start_ready", start_ready, 1);
          repeat (3) begin
            @(negedge clock);
            checkOutput("abort_no_beat", bus.out_valid, 0);
          end
          return;
        end
        model(k, ec, ex, ey, et, el);
        checkOutput($sformatf("col[%0d]", k), bus.out_col, ec);
        checkOutput($sformatf("x[%0d]", k), bus.out_x, ex);
        checkOutput($sformatf("y[%0d]", k), bus.out_y, ey);
        checkOutput($sformatf("transp[%0d]", k), bus.out_transp, et);
        checkOutput($sformatf("last[%0d]", k), bus.out_last, el);
        if (rdy) k++;
      end
    end
    checkOutput("beat_count", k, bwl);
    @(negedge clock);
    checkOutput("after_last_valid", bus.out_valid, 0);
    checkOutput("after_last_start_ready", start_ready, 1);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("rst_start_ready", start_ready, 1);
    checkOutput("rst_valid", bus.out_valid, 0);
    checkOutput("rst_col", bus.out_col, 0);
    checkOutput("rst_x", bus.out_x, 0);
    checkOutput("rst_y", bus.out_y, 0);
    checkOutput("rst_transp", bus.out_transp, 1);
    checkOutput("rst_last", bus.out_last, 0);
    reset_L = 1'b1;

    $display("[TB] identity line");
    applyStimulus(9'd10, 8'd20, 8'd28, 7'd16, 7'd16, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
    runLine(1'b0, -1);

    $display("[TB] double size");
    applyStimulus(9'd10, 8'd20, 8'd28, 7'd16, 7'd16, 1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
    runLine(1'b0, -1);

    $display("[TB] negative scale");
    applyStimulus(9'd10, 8'd20, 8'd28, 7'd16, 7'd16, 1'b0, 16'hFF00, 16'h0000, 16'h0000, 16'h0100);
    runLine(1'b0, -1);

    $display("[TB] backpressure");
    applyStimulus(9'd10, 8'd20, 8'd28, 7'd16, 7'd16, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
    runLine(1'b1, -1);

    $display("[TB] column wrap");
    applyStimulus(9'd500, 8'd20, 8'd28, 7'd16, 7'd16, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
    runLine(1'b0, -1);

    $display("[TB] abort on beat 5");
    applyStimulus(9'd10, 8'd20, 8'd28, 7'd16, 7'd16, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
    runLine(1'b0, 5);

    $display("[TB] zero step");
    applyStimulus(9'd33, 8'd20, 8'd28, 7'd16, 7'd16, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
    runLine(1'b0, -1);

    $display("[TB] extreme params");
    applyStimulus(9'd0, 8'd0, 8'd255, 7'd64, 7'd64, 1'b1, 16'h7FFF, 16'h8001, 16'h8001, 16'h7FFF);
    runLine(1'b1, -1);

    $display("[TB] reset mid-walk");
    applyStimulus(9'd10, 8'd20, 8'd28, 7'd16, 7'd16, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
    repeat (4) @(negedge clock);
    checkOutput("pre_reset_valid", bus.out_valid, 1);
    #2;
    reset_L = 1'b0;
    #1;
    checkOutput("async_rst_valid", bus.out_valid, 0);
    checkOutput("async_rst_start_ready", start_ready, 1);
    @(negedge clock);
    reset_L = 1'b1;
    applyStimulus(9'd10, 8'd20, 8'd28, 7'd16, 7'd16, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
    runLine(1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
